// File: rtl/l1_dcache_if.sv
// rtl/l1_dcache_if.sv - core request, L2 bus and invalidate signals of the L1 data cache
interface l1_dcache_if #(
    parameter int WIDTH      = 128,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [31:0]             req_wdata;
    logic [3:0]              req_wmask;
    logic                    req_ready;
    logic                    resp_valid;
    logic [31:0]             resp_rdata;
    logic                    rw_valid;
    logic                    rw_we;
    logic [ADDR_WIDTH-1:0]   rw_addr;
    logic [WIDTH-1:0]        w_data;
    logic [WIDTH/8-1:0]      w_mask;
    logic                    w_ce;
    logic                    rw_ready;
    logic [WIDTH-1:0]        r_data;
    logic                    inv_valid;
    logic [ADDR_WIDTH-1:0]   inv_addr;
    logic                    inv_ready;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata,
        output rw_valid, rw_we, rw_addr, w_data, w_mask, w_ce,
        input  rw_ready, r_data,
        input  inv_valid, inv_addr,
        output inv_ready
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_rdata,
        input  rw_valid, rw_we, rw_addr, w_data, w_mask, w_ce,
        output rw_ready, r_data,
        output inv_valid, inv_addr,
        input  inv_ready
    );
endinterface

// File: rtl/l1_dcache.sv
// rtl/l1_dcache.sv - direct-mapped write-through no-allocate L1 data cache with L2 invalidation
module l1_dcache #(
    parameter int LINES      = 64,
    parameter int WIDTH      = 128,
    parameter int ADDR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    l1_dcache_if.slave  bus
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - 4;
    localparam int LANES  = WIDTH / 32;
    localparam int MASK_W = WIDTH / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]        state;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WIDTH-1:0]  data_q [LINES];
    logic [1:0]        lat_word;
    logic              inv_sticky;

    logic [IDX_W-1:0]  req_idx, inv_idx, lat_idx;
    logic [TAG_W-1:0]  req_tag, inv_tag, lat_tag;
    logic              req_hit, inv_hit, inv_refill, refill_done;
    logic              unused_addr_bits;

    assign req_idx = bus.req_addr[IDX_W+3:4];
    assign req_tag = bus.req_addr[ADDR_WIDTH-1:IDX_W+4];
    assign inv_idx = bus.inv_addr[IDX_W+3:4];
    assign inv_tag = bus.inv_addr[ADDR_WIDTH-1:IDX_W+4];
    assign lat_idx = bus.rw_addr[IDX_W+3:4];
    assign lat_tag = bus.rw_addr[ADDR_WIDTH-1:IDX_W+4];
    assign unused_addr_bits = ^{bus.req_addr[1:0], bus.inv_addr[3:0], bus.rw_addr[3:0]};

    assign req_hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign inv_hit     = bus.inv_valid && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag);
    assign inv_refill  = bus.inv_valid && (state == REFILL) && (inv_idx == lat_idx) && (inv_tag == lat_tag);
    assign refill_done = (state == REFILL) && bus.rw_ready;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.rw_valid   = (state == REFILL) || (state == WRITE);
    assign bus.rw_we      = (state == WRITE);
    assign bus.w_ce       = (state == WRITE);
    assign bus.inv_ready  = bus.inv_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            valid_q        <= '0;
            lat_word       <= '0;
            inv_sticky     <= 1'b0;
            bus.resp_rdata <= '0;
            bus.rw_addr    <= '0;
            bus.w_data     <= '0;
            bus.w_mask     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_word <= bus.req_addr[3:2];
                        if (!bus.req_we && req_hit) begin
                            bus.resp_rdata <= data_q[req_idx][32*int'(bus.req_addr[3:2]) +: 32];
                            state          <= RESP;
                        end else begin
                            bus.rw_addr <= {bus.req_addr[ADDR_WIDTH-1:4], 4'b0000};
                            inv_sticky  <= 1'b0;
                            if (bus.req_we) begin
                                bus.w_data <= {LANES{bus.req_wdata}};
                                bus.w_mask <= MASK_W'(bus.req_wmask) << (4*int'(bus.req_addr[3:2]));
                                state      <= WRITE;
                                // Store hit updates the local copy now; an invalidate this cycle still clears it below.
                                if (req_hit) begin
                                    for (int b = 0; b < 4; b++) begin
                                        if (bus.req_wmask[b]) begin
                                            data_q[req_idx][32*int'(bus.req_addr[3:2]) + 8*b +: 8] <= bus.req_wdata[8*b +: 8];
                                        end
                                    end
                                end
                            end else begin
                                state <= REFILL;
                            end
                        end
                    end
                end
                REFILL: begin
                    if (inv_refill) inv_sticky <= 1'b1;
                    if (bus.rw_ready) begin
                        data_q[lat_idx]  <= bus.r_data;
                        tag_q[lat_idx]   <= lat_tag;
                        valid_q[lat_idx] <= !(inv_sticky || inv_refill);
                        bus.resp_rdata   <= bus.r_data[32*int'(lat_word) +: 32];
                        state            <= RESP;
                    end
                end
                WRITE: begin
                    if (bus.rw_ready) state <= RESP;
                end
                default: state <= IDLE;
            endcase
            // Old-tag invalidate must not clobber the line being installed this cycle.
            if (inv_hit && !(refill_done && (inv_idx == lat_idx))) begin
                valid_q[inv_idx] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_l1_dcache.sv
// tb/tb_l1_dcache.sv - scoreboard bench for l1_dcache with directed load/store/invalidate/reset vectors
module tb_l1_dcache;
    localparam int WIDTH = 128;
    localparam int AW    = 32;

    localparam logic [127:0] LINE1 = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
    localparam logic [127:0] LINE3 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] LINE4 = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    l1_dcache_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bif ();

    l1_dcache #(.LINES(64), .WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        care;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [15:0]  mask;
        logic [127:0] data;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    resp_t r_exp;
    bus_t  cur;
    logic  have_cur = 1'b0;
    logic  prev_rw  = 1'b0;
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    // Monitor: pops the scoreboards whenever the DUT presents a response or starts a bus request.
    always @(negedge clk) begin
        if (bif.resp_valid) begin
            if (resp_q.size() == 0) begin
                fail("unexpected_resp_valid");
            end else begin
                r_exp = resp_q.pop_front();
                if (r_exp.care) chk("resp_rdata", 128'(bif.resp_rdata), 128'(r_exp.data));
            end
        end
        if (bif.rw_valid && !prev_rw) begin
            if (bus_q.size() == 0) begin
                fail("unexpected_rw_valid");
                have_cur = 1'b0;
            end else begin
                cur      = bus_q.pop_front();
                have_cur = 1'b1;
            end
        end
        if (bif.rw_valid && have_cur) begin
            chk("rw_addr", 128'(bif.rw_addr), 128'(cur.addr));
            chk("rw_we", 128'(bif.rw_we), 128'(cur.we));
            chk("w_ce", 128'(bif.w_ce), 128'(cur.we));
            if (cur.we) begin
                chk("w_mask", 128'(bif.w_mask), 128'(cur.mask));
                chk("w_data", bif.w_data, cur.data);
            end
        end
        if (!bif.rw_valid) have_cur = 1'b0;
        prev_rw = bif.rw_valid;
    end

    task automatic exp_resp(logic care, logic [31:0] d);
        resp_t r;
        r.care = care;
        r.data = d;
        resp_q.push_back(r);
    endtask

    task automatic exp_bus(logic [31:0] a, logic we, logic [15:0] m, logic [127:0] d);
        bus_t b;
        b.addr = a;
        b.we   = we;
        b.mask = m;
        b.data = d;
        bus_q.push_back(b);
    endtask

    task automatic issue(logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] wm);
        int t = 0;
        while (!bif.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bif.req_ready) fail("req_ready_timeout");
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = a;
        bif.req_wdata = wd;
        bif.req_wmask = wm;
        @(negedge clk);
        bif.req_valid = 1'b0;
    endtask

    task automatic pulse_inv(logic [31:0] a);
        bif.inv_valid = 1'b1;
        bif.inv_addr  = a;
        #1;
        chk("inv_ready_same_cycle", 128'(bif.inv_ready), 128'(1));
        @(negedge clk);
        bif.inv_valid = 1'b0;
    endtask

    task automatic l2_respond(logic [127:0] line, int delay, logic do_inv, logic [31:0] inv_a);
        int t = 0;
        while (!bif.rw_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bif.rw_valid) begin
            fail("rw_valid_timeout");
        end else begin
            repeat (delay) @(negedge clk);
            if (do_inv) pulse_inv(inv_a);
            bif.rw_ready = 1'b1;
            bif.r_data   = line;
            @(negedge clk);
            bif.rw_ready = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (resp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    task automatic load_miss(logic [31:0] a, logic [127:0] line, logic [31:0] word, logic do_inv);
        exp_bus({a[31:4], 4'h0}, 1'b0, 16'h0, 128'h0);
        exp_resp(1'b1, word);
        issue(1'b0, a, 32'h0, 4'h0);
        l2_respond(line, 2, do_inv, a);
        wait_done();
    endtask

    task automatic load_hit(logic [31:0] a, logic [31:0] word);
        exp_resp(1'b1, word);
        issue(1'b0, a, 32'h0, 4'h0);
        chk("hit_latency_resp_valid", 128'(bif.resp_valid), 128'(1));
        chk("hit_no_rw_valid", 128'(bif.rw_valid), 128'(0));
        wait_done();
    endtask

    task automatic store(logic [31:0] a, logic [31:0] wd, logic [3:0] wm, logic [15:0] bm, logic do_inv);
        exp_bus({a[31:4], 4'h0}, 1'b1, bm, {4{wd}});
        exp_resp(1'b0, 32'h0);
        issue(1'b1, a, wd, wm);
        l2_respond(128'h0, 3, do_inv, 32'h100);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.req_wmask = '0;
        bif.rw_ready  = 1'b0;
        bif.r_data    = '0;
        bif.inv_valid = 1'b0;
        bif.inv_addr  = '0;
        repeat (2) @(negedge clk);
        chk("rst_rw_valid", 128'(bif.rw_valid), 128'(0));
        chk("rst_resp_valid", 128'(bif.resp_valid), 128'(0));
        chk("rst_req_ready", 128'(bif.req_ready), 128'(1));
        chk("rst_rw_addr", 128'(bif.rw_addr), 128'(0));
        chk("rst_w_mask", 128'(bif.w_mask), 128'(0));
        chk("rst_w_data", bif.w_data, 128'h0);
        chk("rst_resp_rdata", 128'(bif.resp_rdata), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        load_miss(32'h100, LINE1, 32'hBBBBAAAA, 1'b0);
        load_hit(32'h104, 32'hDDDDCCCC);
        store(32'h108, 32'h12345678, 4'hF, 16'h0F00, 1'b0);
        load_hit(32'h108, 32'h12345678);

        store(32'h10C, 32'hAABBCCDD, 4'h3, 16'h3000, 1'b1);
        load_miss(32'h10C, LINE1, 32'h44443333, 1'b0);

        pulse_inv(32'h100);
        load_miss(32'h100, LINE3, 32'hA0A0A0A0, 1'b1);
        load_miss(32'h100, LINE3, 32'hA0A0A0A0, 1'b0);

        load_miss(32'h500, LINE4, 32'hB0B0B0B0, 1'b0);
        load_hit(32'h504, 32'hB1B1B1B1);
        load_miss(32'h100, LINE1, 32'hBBBBAAAA, 1'b0);

        exp_bus(32'h200, 1'b0, 16'h0, 128'h0);
        issue(1'b0, 32'h200, 32'h0, 4'h0);
        chk("refill_pending_rw_valid", 128'(bif.rw_valid), 128'(1));
        rst           = 1'b1;
        bif.inv_valid = 1'b1;
        bif.inv_addr  = 32'h100;
        #1;
        chk("inv_ready_in_reset", 128'(bif.inv_ready), 128'(1));
        @(negedge clk);
        chk("rst_abandon_rw_valid", 128'(bif.rw_valid), 128'(0));
        chk("rst_abandon_resp_valid", 128'(bif.resp_valid), 128'(0));
        rst           = 1'b0;
        bif.inv_valid = 1'b0;
        repeat (3) @(negedge clk);

        load_miss(32'h100, LINE1, 32'hBBBBAAAA, 1'b0);
        load_hit(32'h108, 32'h22221111);

        repeat (3) @(negedge clk);
        chk("resp_q_drained", 128'(resp_q.size()), 128'(0));
        chk("bus_q_drained", 128'(bus_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
